// File: rtl/three_parallel_sequencer.sv
// Packs serial samples into 3-sample blocks for the 3-parallel FIR, strobes filt_ce once per block,
// and re-serializes the filter results through a credit-guarded output FIFO (padding never emitted).
module three_parallel_sequencer #(
    parameter int DW_IN     = 16,
    parameter int DW_OUT    = 64,
    parameter int LAT_P     = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    output logic [DW_IN-1:0]  din1,
    output logic [DW_IN-1:0]  din2,
    output logic [DW_IN-1:0]  din3,
    output logic              filt_ce,
    input  logic [DW_OUT-1:0] dout1,
    input  logic [DW_OUT-1:0] dout2,
    input  logic [DW_OUT-1:0] dout3,
    output logic [DW_OUT-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FW = $clog2(OUT_DEPTH + 1);
    localparam int CW = $clog2(LAT_P + OUT_DEPTH + 2) + 1;

    typedef enum logic {COLLECT, PAD_WAIT} state_t;

    state_t             state, state_n;
    logic               run;
    logic [1:0]         phase, phase_n;
    logic [DW_IN-1:0]   slot0, slot1, slot0_n, slot1_n;
    logic               issue, accept, credit_ok;
    logic [DW_IN-1:0]   b1, b2, b3;
    logic [1:0]         bcnt;
    logic               blast;

    logic [1:0]         ce_cnt;
    logic               ce_last;
    logic [LAT_P-1:0]   trk_vld;
    logic [1:0]         trk_cnt  [LAT_P];
    logic               trk_last [LAT_P];
    logic [CW-1:0]      inflight, used;

    logic [DW_OUT-1:0]  f_d1 [OUT_DEPTH];
    logic [DW_OUT-1:0]  f_d2 [OUT_DEPTH];
    logic [DW_OUT-1:0]  f_d3 [OUT_DEPTH];
    logic [1:0]         f_cnt  [OUT_DEPTH];
    logic               f_last [OUT_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [FW-1:0]      fcnt;
    logic [1:0]         out_idx;
    logic               push, pop;

    // Blocks issued but not yet in the FIFO still hold a credit: the ce register plus the tracker.
    always_comb begin
        inflight = CW'(filt_ce);
        for (int i = 0; i < LAT_P; i++) inflight = inflight + CW'(trk_vld[i]);
    end
    assign used      = inflight + CW'(fcnt);
    assign credit_ok = used < CW'(OUT_DEPTH);

    assign s_ready = run & ~rst & (state == COLLECT) & ~((phase == 2'd2) & ~credit_ok);
    assign accept  = s_valid & s_ready;
    assign busy    = (phase != 2'd0) | (state == PAD_WAIT) | (inflight != '0) | (fcnt != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        slot0_n = slot0;
        slot1_n = slot1;
        issue   = 1'b0;
        b1      = slot0;
        b2      = slot1;
        b3      = '0;
        bcnt    = 2'd3;
        blast   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    case (phase)
                        2'd0:    begin slot0_n = s_data; phase_n = 2'd1; end
                        2'd1:    begin slot1_n = s_data; phase_n = 2'd2; end
                        default: begin issue = 1'b1; b3 = s_data; phase_n = 2'd0; end
                    endcase
                end
                // Flush sees the phase after this cycle's acceptance; a just-completed block makes it a no-op.
                if (flush && phase_n != 2'd0) begin
                    b1    = slot0_n;
                    b2    = (phase_n == 2'd2) ? slot1_n : '0;
                    b3    = '0;
                    bcnt  = phase_n;
                    blast = 1'b1;
                    if (credit_ok) begin
                        issue   = 1'b1;
                        phase_n = 2'd0;
                    end else begin
                        state_n = PAD_WAIT;
                    end
                end
            end
            default: begin
                b2    = (phase == 2'd2) ? slot1 : '0;
                bcnt  = phase;
                blast = 1'b1;
                if (credit_ok) begin
                    issue   = 1'b1;
                    phase_n = 2'd0;
                    state_n = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run     <= 1'b0;
            phase   <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
            din1    <= '0;
            din2    <= '0;
            din3    <= '0;
            filt_ce <= 1'b0;
            ce_cnt  <= 2'd0;
            ce_last <= 1'b0;
            trk_vld <= '0;
            for (int i = 0; i < LAT_P; i++) begin
                trk_cnt[i]  <= 2'd0;
                trk_last[i] <= 1'b0;
            end
        end else begin
            run     <= 1'b1;
            phase   <= phase_n;
            slot0   <= slot0_n;
            slot1   <= slot1_n;
            filt_ce <= issue;
            if (issue) begin
                din1    <= b1;
                din2    <= b2;
                din3    <= b3;
                ce_cnt  <= bcnt;
                ce_last <= blast;
            end
            for (int i = LAT_P - 1; i > 0; i--) begin
                trk_vld[i]  <= trk_vld[i-1];
                trk_cnt[i]  <= trk_cnt[i-1];
                trk_last[i] <= trk_last[i-1];
            end
            trk_vld[0]  <= filt_ce;
            trk_cnt[0]  <= ce_cnt;
            trk_last[0] <= ce_last;
        end
    end

    assign push    = trk_vld[LAT_P-1];
    assign m_valid = (fcnt != '0);
    assign pop     = m_valid & m_ready & (out_idx == f_cnt[rd_ptr] - 2'd1);
    assign m_last  = m_valid & f_last[rd_ptr] & (out_idx == f_cnt[rd_ptr] - 2'd1);

    always_comb begin
        m_data = '0;
        if (m_valid) begin
            case (out_idx)
                2'd0:    m_data = f_d1[rd_ptr];
                2'd1:    m_data = f_d2[rd_ptr];
                default: m_data = f_d3[rd_ptr];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_d1[wr_ptr]   <= dout1;
            f_d2[wr_ptr]   <= dout2;
            f_d3[wr_ptr]   <= dout3;
            f_cnt[wr_ptr]  <= trk_cnt[LAT_P-1];
            f_last[wr_ptr] <= trk_last[LAT_P-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            out_idx <= 2'd0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
            if (pop)                     out_idx <= 2'd0;
            else if (m_valid && m_ready) out_idx <= out_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_three_parallel_sequencer.sv
// Directed bench for three_parallel_sequencer with a one-cycle stub filter (dout_k = sext(din_k)).
module tb_three_parallel_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid, s_ready, flush;
    logic [15:0] din1, din2, din3;
    logic        filt_ce;
    logic [63:0] dout1, dout2, dout3;
    logic [63:0] m_data;
    logic        m_valid, m_ready, m_last, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_ce = -1;
    int first_mv = -1;

    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    logic [47:0] ce_q[$];

    three_parallel_sequencer dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .flush(flush),
        .din1(din1), .din2(din2), .din3(din3), .filt_ce(filt_ce),
        .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (filt_ce) begin
            dout1 <= {{48{din1[15]}}, din1};
            dout2 <= {{48{din2[15]}}, din2};
            dout3 <= {{48{din3[15]}}, din3};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
            if (filt_ce) ce_q.push_back({din1, din2, din3});
            if (filt_ce && first_ce < 0) first_ce = cyc;
            if (m_valid && first_mv < 0) first_mv = cyc;
        end
    end

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] mk(input bit l, input int v);
        logic signed [63:0] t;
        t = 64'(v);
        return {l, t};
    endfunction

    function automatic logic [47:0] mkd(input int a, input int b, input int c);
        return {16'(a), 16'(b), 16'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit fl);
        bit ok;
        ok = 1'b0;
        s_data  = 16'(v);
        s_valid = 1'b1;
        flush   = fl;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("s_ready_wait", {64'd0, s_ready}, 65'd1);
        tick();
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_busy"}, {64'd0, busy}, 65'd0);
        tick();
    endtask

    task automatic cmp_outs(input string tag);
        chk({tag, "_count"}, 65'(got_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        ce_q.delete();
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
        dout1 = '0; dout2 = '0; dout3 = '0;

        // 1: reset values
        repeat (3) tick();
        @(negedge clk);
        chk("rst_s_ready", {64'd0, s_ready}, 65'd0);
        chk("rst_outs", {60'd0, filt_ce, m_valid, m_last, busy}, 65'd0);
        chk("rst_m_data", {1'b0, m_data}, 65'd0);
        chk("rst_din", {17'd0, din1, din2, din3}, 65'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_s_ready", {64'd0, s_ready}, 65'd1);
        tick();

        // 2: two full blocks, sink always ready
        clear();
        first_ce = -1; first_mv = -1;
        m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) send(i, 1'b0);
        drain("t2");
        chk("t2_ce_n", 65'(ce_q.size()), 65'd2);
        if (ce_q.size() == 2) begin
            chk("t2_ce0", {17'd0, ce_q[0]}, {17'd0, mkd(1, 2, 3)});
            chk("t2_ce1", {17'd0, ce_q[1]}, {17'd0, mkd(4, 5, 6)});
        end
        chk("t2_latency", 65'(first_mv - first_ce), 65'd2);
        for (int i = 1; i <= 6; i++) exp_q.push_back(mk(1'b0, i));
        cmp_outs("t2");

        // 3: backpressure until credit runs out
        clear();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        s_data = 16'd9;
        s_valid = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("t3_stall_s_ready", {64'd0, s_ready}, 65'd0);
        chk("t3_stall_busy", {64'd0, busy}, 65'd1);
        tick();
        m_ready = 1'b1;
        send(9, 1'b0);
        drain("t3");
        chk("t3_ce_n", 65'(ce_q.size()), 65'd3);
        for (int i = 1; i <= 9; i++) exp_q.push_back(mk(1'b0, i));
        cmp_outs("t3");

        // 4: partial block flush
        clear();
        send(-3, 1'b0);
        send(7, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t4");
        chk("t4_ce_n", 65'(ce_q.size()), 65'd1);
        if (ce_q.size() == 1) chk("t4_ce0", {17'd0, ce_q[0]}, {17'd0, mkd(-3, 7, 0)});
        exp_q.push_back(mk(1'b0, -3));
        exp_q.push_back(mk(1'b1, 7));
        cmp_outs("t4");

        // 5: flush at phase 0 and together with the third sample
        clear();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        send(10, 1'b0);
        send(11, 1'b0);
        send(12, 1'b1);
        drain("t5");
        chk("t5_ce_n", 65'(ce_q.size()), 65'd1);
        if (ce_q.size() == 1) chk("t5_ce0", {17'd0, ce_q[0]}, {17'd0, mkd(10, 11, 12)});
        for (int i = 10; i <= 12; i++) exp_q.push_back(mk(1'b0, i));
        cmp_outs("t5");

        // 6: reset mid-stream discards everything
        m_ready = 1'b0;
        for (int i = 30; i <= 34; i++) send(i, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_busy_after_rst", {64'd0, busy}, 65'd0);
        tick();
        clear();
        m_ready = 1'b1;
        for (int i = 20; i <= 22; i++) send(i, 1'b0);
        drain("t6");
        for (int i = 20; i <= 22; i++) exp_q.push_back(mk(1'b0, i));
        cmp_outs("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
